dot_writeback: RTL and testbench

- Write-side counterpart of the dot-product layer's RAM fetch.
- Captures one finished layer result and writes it back into layer RAM as packed words:
  - Input: 384 elements, 12 groups x 32 channels.
  - Each RAM word holds 9 elements, the same word format the next layer fetches one address at a time.
- Sits between a dot-layer output (q/valid) and the single-port activation RAM write port.

---
 rtl/dot_writeback_pkg.sv | 23 ++
 rtl/dot_writeback_relu_clamp.sv | 13 +
 rtl/dot_writeback.sv | 137 +++++++++++++
 tb/tb_dot_writeback.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dot_writeback_pkg.sv
// Shared constants and types for the dot-product layer writeback path.
// Element width comes from the shared `DOT_DATA_LEN define.
`ifndef DOT_DATA_LEN
`define DOT_DATA_LEN 16
`endif

package dot_writeback_pkg;

    // Fetch and writeback must agree on the word packing.
    localparam int WORD_ELEMS = 9;
    localparam int NWORDS_384 = 43;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE
    } wb_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/dot_writeback_relu_clamp.sv
// Per-element ReLU clamp: negative two's-complement values become zero.
// With EN=0 the element passes through untouched.
module relu_clamp #(
    parameter int DATA_LEN = 16,
    parameter bit EN       = 1'b1
) (
    input  logic [DATA_LEN-1:0] din,
    output logic [DATA_LEN-1:0] dout
);

    assign dout = (EN && din[DATA_LEN-1]) ? '0 : din;

endmodule

// File: rtl/dot_writeback.sv
// Captures one dot-layer result and streams it into activation RAM as packed words.
// Optional build macro DOT_WRITEBACK_RELU_EN clamps negative elements at capture.
`ifndef DOT_DATA_LEN
`define DOT_DATA_LEN 16
`endif

module dot_writeback
    import dot_writeback_pkg::*;
#(
    parameter int DATA_LEN   = `DOT_DATA_LEN,
    parameter int N_ELEMS    = 384,
    parameter int WORD_ELEMS = dot_writeback_pkg::WORD_ELEMS,
    parameter int ADDR_W     = 9,
    parameter int BASE_ADDR  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load,
    input  logic                           in_valid,
    input  logic [N_ELEMS*DATA_LEN-1:0]    din,
    output logic                           we,
    output logic [ADDR_W-1:0]              waddr,
    output logic [WORD_ELEMS*DATA_LEN-1:0] wdata,
    output logic                           busy,
    output logic                           done
);

    localparam int NWORDS = ceil_div(N_ELEMS, WORD_ELEMS);
    localparam int BUF_W  = N_ELEMS * DATA_LEN;
    localparam int WORD_W = WORD_ELEMS * DATA_LEN;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

`ifdef DOT_WRITEBACK_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    wb_state_e           state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BUF_W-1:0]    din_c;

    for (genvar k = 0; k < N_ELEMS; k++) begin : g_clamp
        relu_clamp #(.DATA_LEN(DATA_LEN), .EN(RELU_ON)) u_relu (
            .din  (din[k*DATA_LEN +: DATA_LEN]),
            .dout (din_c[k*DATA_LEN +: DATA_LEN])
        );
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (load && in_valid) begin
                    buf_d   = din_c;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!load) begin
                    // Abandon the partial transfer; a new capture starts from word 0.
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = BASE_A + ADDR_W'(cnt_q);
                    wdata_d = buf_q[WORD_W-1:0];
                    buf_d   = buf_q >> WORD_W;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NWORDS - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
                if (!load) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_dot_writeback.sv
// Directed bench for dot_writeback: packing, hold/re-arm, abort, address wrap, ReLU, async reset.
module tb_dot_writeback;

    localparam int DL = 16;
    localparam int NE = 384;
    localparam int WE = 9;
    localparam int AW = 9;

    logic              clk = 1'b0;
    logic              rst_n, load, in_valid;
    logic [NE*DL-1:0]  din;
    logic              we, busy, done, w_we, w_busy, w_done;
    logic [AW-1:0]     waddr, w_waddr;
    logic [WE*DL-1:0]  wdata, w_wdata;
    int                total = 0;
    int                bad = 0;
    int                nw, mx, lw;

    always #5 clk = ~clk;

    dot_writeback #(.DATA_LEN(DL), .N_ELEMS(NE), .WORD_ELEMS(WE), .ADDR_W(AW), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .load(load), .in_valid(in_valid), .din(din),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
    );

    dot_writeback #(.DATA_LEN(DL), .N_ELEMS(NE), .WORD_ELEMS(WE), .ADDR_W(AW), .BASE_ADDR(500)) u_wrap (
        .clk(clk), .rst_n(rst_n), .load(load), .in_valid(in_valid), .din(din),
        .we(w_we), .waddr(w_waddr), .wdata(w_wdata), .busy(w_busy), .done(w_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic capture();
        load = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Observe ncyc cycles; every write is checked against its running index.
    task automatic watch(input int ncyc, input int abort_at, input bit chk_data,
                         output int n, output int max_a, output int last_wrap);
        n = 0;
        max_a = -1;
        last_wrap = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (we) begin
                chk("waddr", waddr, n);
                chk("wrap_we", w_we, 1);
                chk("wrap_waddr", w_waddr, (500 + n) % 512);
                if (n < 42) chk("early_done", done, 0);
                if (chk_data && (n == 0 || n == 41 || n == 42)) begin
                    for (int e = 0; e < WE; e++) begin
                        int v;
                        v = n * WE + e;
                        chk($sformatf("w%0d_s%0d", n, e), wdata[e*DL +: DL], (v < NE) ? v : 0);
                    end
                end
                if (int'(waddr) > max_a) max_a = int'(waddr);
                last_wrap = int'(w_waddr);
                n++;
                if (abort_at >= 0 && int'(waddr) == abort_at) load = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < NE; k++) din[k*DL +: DL] = k[DL-1:0];
        step(2);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata[31:0], 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step(1);

        // no capture while load is low
        in_valid = 1'b1;
        step(2);
        chk("noload_busy", busy, 0);
        in_valid = 1'b0;

        // ramp packing, plus wrap instance
        capture();
        chk("cap_busy", busy, 1);
        chk("cap_we", we, 0);
        watch(46, -1, 1'b1, nw, mx, lw);
        chk("ramp_nwords", nw, 43);
        chk("wrap_last", lw, 30);
        chk("ramp_done", done, 1);
        chk("ramp_busy", busy, 0);
        chk("ramp_we", we, 0);

        // hold with in_valid high: no re-capture
        in_valid = 1'b1;
        watch(5, -1, 1'b0, nw, mx, lw);
        chk("hold_nwords", nw, 0);
        chk("hold_done", done, 1);
        load = 1'b0;
        in_valid = 1'b0;
        step(1);
        chk("drop_done", done, 0);

        // re-arm
        capture();
        watch(46, -1, 1'b0, nw, mx, lw);
        chk("rearm_nwords", nw, 43);
        chk("rearm_done", done, 1);
        load = 1'b0;
        step(1);

        // abort at waddr 20
        capture();
        watch(50, 20, 1'b0, nw, mx, lw);
        chk("abort_nwords", nw, 21);
        chk("abort_max", mx, 20);
        chk("abort_we", we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        capture();
        watch(3, -1, 1'b0, nw, mx, lw);
        chk("restart_nwords", nw, 3);
        load = 1'b0;
        step(2);

        // ReLU behaviour on word 0
        din[5*DL +: DL] = 16'hFFFF;
        din[6*DL +: DL] = 16'h7FFF;
        capture();
        step(1);
        chk("relu_we", we, 1);
        chk("relu_waddr", waddr, 0);
`ifdef DOT_WRITEBACK_RELU_EN
        chk("relu_s5", wdata[5*DL +: DL], 16'h0000);
`else
        chk("relu_s5", wdata[5*DL +: DL], 16'hFFFF);
`endif
        chk("relu_s6", wdata[6*DL +: DL], 16'h7FFF);

        // async reset mid-write, checked before any clock edge
        step(5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", we, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_waddr", waddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_we", we, 0);
        capture();
        step(1);
        chk("post_rst_first_we", we, 1);
        chk("post_rst_first_addr", waddr, 0);
        load = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
